baud_ctrl: RTL and testbench
============================

# baud_ctrl

Runtime baud-rate controller for the UART. Holds the active baud selection, converts it to a clock divisor, and generates the 16x oversampling tick for RX and the 1x bit tick for TX. A configuration request is accepted at any time, but the rate change is applied only when both TX and RX report idle, so no frame in flight is corrupted. Sits between the register/config interface and the TX/RX cores.

## Interface
- pSYS_CLK_FREQ, 100000000, system clock frequency in Hz
- pDEFAULT_SEL, 6, baud select loaded at reset (6 = 9600)
- pDIV_W, 16, divisor width; must hold the largest divisor (110 baud)

- sys_clk  in  1  system clock
- Async_rst  in  1  reset; asynchronous, active-low; clock is sys_clk
- cfg_valid  in  1  new baud select offered
- cfg_sel  in  4  requested baud select index
- cfg_ready  out  1  controller can accept a request
- cfg_err  out  1  one-cycle pulse: offered cfg_sel is invalid (14 or 15)
- tx_busy  in  1  TX frame in progress
- rx_busy  in  1  RX frame in progress
- active_sel  out  4  select index currently driving the ticks
- tick_16x  out  1  one-cycle pulse at 16 x baud (RX oversampling)
- tick_1x  out  1  one-cycle pulse at baud (TX bit strobe)

## Operation
- Select map: 0:110, 1:300, 2:600, 3:1200, 4:2400, 5:4800, 6:9600, 7:14400, 8:19200, 9:38400, 10:57600, 11:115200, 12:128000, 13:256000. 14 and 15 are invalid.
- Divisor is floor(pSYS_CLK_FREQ / (16 x baud)) - 1, computed at elaboration as a constant per index; no runtime divide.
- Tick generation:
  - div_cnt counts 0..div. tick_16x = 1 in the cycle div_cnt == div, after which div_cnt wraps to 0. Period is div+1 cycles.
  - os_cnt (4 bits) increments on each tick_16x.
  - tick_1x = tick_16x AND os_cnt == 15, so tick_1x coincides with every 16th tick_16x.
- FSM states: RUN, PEND, LOAD.
  - RUN: cfg_ready = 1.
    - cfg_valid with valid sel: latch pend_sel, go to PEND.
    - cfg_valid with invalid sel: cfg_err pulses for 1 cycle, stay in RUN, request dropped.
  - PEND: cfg_ready = 0. Ticks continue at the old rate. When tx_busy == 0 AND rx_busy == 0 in a cycle, go to LOAD; otherwise wait indefinitely.
  - LOAD: load div from pend_sel, set active_sel = pend_sel, clear div_cnt and os_cnt, force both ticks to 0, go to RUN.
- Requesting the select already active still walks PEND and LOAD, so counters are re-phased.
- Any cfg_valid while cfg_ready = 0 is ignored; cfg_err is not raised for it.

## Timing
- Reset values:
  - Outputs: cfg_ready = 1, cfg_err = 0, tick_16x = 0, tick_1x = 0, active_sel = pDEFAULT_SEL.
  - Internal: state RUN, div = divisor(pDEFAULT_SEL), div_cnt = 0, os_cnt = 0.
- All outputs are registered.
- First tick_16x is asserted in cycle div+1 after reset release, i.e. div_cnt reaches div.
- Request accepted at clock edge T (cfg_valid and cfg_ready both high):
  - Busy lines low at T+1: LOAD is entered at edge T+1, new div and active_sel are visible after edge T+2, and cfg_ready = 1 again after T+2.
  - Minimum request-to-apply time is 2 cycles.
- First tick_16x at the new rate occurs div_new+1 cycles after the LOAD edge.
- A tick that would fall in the LOAD cycle is suppressed.
- A busy line that rises while in PEND extends the wait. Only the cycle in which both lines are low matters.
- Reset asserted mid-PEND or mid-LOAD: the pending request is discarded and the controller returns to the default rate.

## Structure
- Package baud_pkg holds:
  - Select index constants (SEL_110 .. SEL_256000, SEL_MAX = 13)
  - Constant function baud_div(sel, clk_freq) returning pDIV_W bits
  - FSM state encoding
- Sub-module baud_tick_gen (div, clear -> tick_16x, tick_1x) contains div_cnt and os_cnt. The FSM lives in baud_ctrl.

## Test plan
- Reset with defaults: tick_16x period is 651 cycles (div 650); tick_1x period is 10416 cycles; active_sel = 6.
- Idle busy lines, cfg_sel = 11: active_sel becomes 11 two cycles after accept; tick_16x period becomes 54 cycles (div 53); tick_1x period becomes 864 cycles.
- tx_busy held high for 500 cycles after a request for sel 13: old period is kept and cfg_ready stays 0 throughout; switch occurs 2 cycles after tx_busy falls; new tick_16x period is 24 cycles.
- cfg_sel = 15 offered in RUN: cfg_err pulses exactly 1 cycle; active_sel and tick period are unchanged.
- Second cfg_valid during PEND: ignored; only the first select is applied.
- Async_rst pulsed during PEND with sel 0 pending: after release, active_sel = 6 and tick_16x period is 651 cycles; sel 0 (div 56817) is never applied.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared definitions for the UART baud-rate controller: select indices,
// elaboration-time divisor calculation and FSM state encoding.
package baud_pkg;

    localparam logic [3:0] SEL_110    = 4'd0;
    localparam logic [3:0] SEL_300    = 4'd1;
    localparam logic [3:0] SEL_600    = 4'd2;
    localparam logic [3:0] SEL_1200   = 4'd3;
    localparam logic [3:0] SEL_2400   = 4'd4;
    localparam logic [3:0] SEL_4800   = 4'd5;
    localparam logic [3:0] SEL_9600   = 4'd6;
    localparam logic [3:0] SEL_14400  = 4'd7;
    localparam logic [3:0] SEL_19200  = 4'd8;
    localparam logic [3:0] SEL_38400  = 4'd9;
    localparam logic [3:0] SEL_57600  = 4'd10;
    localparam logic [3:0] SEL_115200 = 4'd11;
    localparam logic [3:0] SEL_128000 = 4'd12;
    localparam logic [3:0] SEL_256000 = 4'd13;
    localparam logic [3:0] SEL_MAX    = 4'd13;

    typedef enum logic [1:0] {
        StRun,
        StPend,
        StLoad
    } state_e;

    // Baud rate in Hz for a select index; 0 marks an invalid index.
    function automatic int unsigned baud_rate(input logic [3:0] sel);
        case (sel)
            SEL_110:    return 110;
            SEL_300:    return 300;
            SEL_600:    return 600;
            SEL_1200:   return 1200;
            SEL_2400:   return 2400;
            SEL_4800:   return 4800;
            SEL_9600:   return 9600;
            SEL_14400:  return 14400;
            SEL_19200:  return 19200;
            SEL_38400:  return 38400;
            SEL_57600:  return 57600;
            SEL_115200: return 115200;
            SEL_128000: return 128000;
            SEL_256000: return 256000;
            default:    return 0;
        endcase
    endfunction

    // Divisor for the 16x tick: floor(clk / (16 * baud)) - 1. Only ever
    // evaluated on constants; the caller narrows the result to its width.
    function automatic int unsigned baud_div(input logic [3:0] sel,
                                             input int unsigned clk_freq);
        int unsigned rate;
        rate = baud_rate(sel);
        if (rate == 0) return 0;
        return clk_freq / (16 * rate) - 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// 16x oversampling and 1x bit tick generator driven by a programmable divisor.
module baud_tick_gen #(
    parameter int unsigned pDIV_W = 16
) (
    input  logic              sys_clk,
    input  logic              Async_rst,
    input  logic [pDIV_W-1:0] div,
    input  logic              clear,
    output logic              tick_16x,
    output logic              tick_1x
);

    logic [pDIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]        os_cnt_q, os_cnt_d;
    logic              tick_16x_q, tick_16x_d;
    logic              tick_1x_q, tick_1x_d;

    // Next counter values; ticks are decoded from the next count so they are
    // registered yet high in the same cycle the count equals div.
    always_comb begin
        div_cnt_d  = '0;
        os_cnt_d   = '0;
        tick_16x_d = 1'b0;
        tick_1x_d  = 1'b0;
        if (!clear) begin
            div_cnt_d  = (div_cnt_q == div) ? '0 : div_cnt_q + pDIV_W'(1);
            os_cnt_d   = tick_16x_q ? os_cnt_q + 4'd1 : os_cnt_q;
            tick_16x_d = (div_cnt_d == div);
            tick_1x_d  = tick_16x_d && (os_cnt_d == 4'd15);
        end
    end

    // Counter and tick registers.
    always_ff @(posedge sys_clk or negedge Async_rst) begin
        if (!Async_rst) begin
            div_cnt_q  <= '0;
            os_cnt_q   <= '0;
            tick_16x_q <= 1'b0;
            tick_1x_q  <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            os_cnt_q   <= os_cnt_d;
            tick_16x_q <= tick_16x_d;
            tick_1x_q  <= tick_1x_d;
        end
    end

    assign tick_16x = tick_16x_q;
    assign tick_1x  = tick_1x_q;

endmodule

// File: rtl/baud_ctrl.sv
// Runtime baud-rate controller: accepts a new baud select at any time and
// applies it only once TX and RX are both idle, then re-phases the ticks.
module baud_ctrl
    import baud_pkg::*;
#(
    parameter int unsigned pSYS_CLK_FREQ = 100000000,
    parameter logic [3:0]  pDEFAULT_SEL  = 4'd6,
    parameter int unsigned pDIV_W        = 16
) (
    input  logic       sys_clk,
    input  logic       Async_rst,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_sel,
    output logic       cfg_ready,
    output logic       cfg_err,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic [3:0] active_sel,
    output logic       tick_16x,
    output logic       tick_1x
);

    localparam logic [pDIV_W-1:0] DefaultDiv =
        pDIV_W'(baud_div(pDEFAULT_SEL, pSYS_CLK_FREQ));

    // Constant divisor table; invalid indices hold 0 and are never loaded.
    logic [pDIV_W-1:0] div_table [16];
    for (genvar gi = 0; gi < 16; gi++) begin : g_div
        localparam int unsigned DivVal = baud_div(4'(gi), pSYS_CLK_FREQ);
        assign div_table[gi] = pDIV_W'(DivVal);
    end

    state_e            state_q, state_d;
    logic [3:0]        pend_sel_q, pend_sel_d;
    logic [3:0]        active_sel_q;
    logic [pDIV_W-1:0] div_q;
    logic              cfg_ready_q;
    logic              cfg_err_q, cfg_err_d;
    logic              load;
    logic              tick_clear;

    // Next-state logic: latch valid requests, wait for idle, then load.
    always_comb begin
        state_d    = state_q;
        pend_sel_d = pend_sel_q;
        cfg_err_d  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (cfg_valid) begin
                    if (cfg_sel <= SEL_MAX) begin
                        pend_sel_d = cfg_sel;
                        state_d    = StPend;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StPend: begin
                if (!tx_busy && !rx_busy) state_d = StLoad;
            end
            StLoad: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    assign load = (state_q == StLoad);
    // Clearing on the edge into LOAD as well keeps both ticks low during LOAD.
    assign tick_clear = load || (state_d == StLoad);

    // State, request and active-rate registers.
    always_ff @(posedge sys_clk or negedge Async_rst) begin
        if (!Async_rst) begin
            state_q      <= StRun;
            pend_sel_q   <= pDEFAULT_SEL;
            active_sel_q <= pDEFAULT_SEL;
            div_q        <= DefaultDiv;
            cfg_ready_q  <= 1'b1;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_sel_q  <= pend_sel_d;
            cfg_ready_q <= (state_d == StRun);
            cfg_err_q   <= cfg_err_d;
            if (load) begin
                div_q        <= div_table[pend_sel_q];
                active_sel_q <= pend_sel_q;
            end
        end
    end

    baud_tick_gen #(
        .pDIV_W (pDIV_W)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .Async_rst (Async_rst),
        .div       (div_q),
        .clear     (tick_clear),
        .tick_16x  (tick_16x),
        .tick_1x   (tick_1x)
    );

    assign cfg_ready  = cfg_ready_q;
    assign cfg_err    = cfg_err_q;
    assign active_sel = active_sel_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed self-checking bench for baud_ctrl at 100 MHz.
module tb_baud_ctrl;

    logic       sys_clk   = 1'b0;
    logic       Async_rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_sel   = 4'd0;
    logic       tx_busy   = 1'b0;
    logic       rx_busy   = 1'b0;
    logic       cfg_ready, cfg_err, tick_16x, tick_1x;
    logic [3:0] active_sel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    baud_ctrl #(
        .pSYS_CLK_FREQ (100000000),
        .pDEFAULT_SEL  (4'd6),
        .pDIV_W        (16)
    ) dut (
        .sys_clk    (sys_clk),
        .Async_rst  (Async_rst),
        .cfg_valid  (cfg_valid),
        .cfg_sel    (cfg_sel),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .tx_busy    (tx_busy),
        .rx_busy    (rx_busy),
        .active_sel (active_sel),
        .tick_16x   (tick_16x),
        .tick_1x    (tick_1x)
    );

    // Cycles until the next tick_16x, sampled on negedges; -1 if the bound expires.
    task automatic next_tick16(input int limit, output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (tick_16x !== 1'b1 && n < limit);
        if (tick_16x !== 1'b1) n = -1;
    endtask

    task automatic next_tick1x(input int limit, output int n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (tick_1x !== 1'b1 && n < limit);
        if (tick_1x !== 1'b1) n = -1;
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge sys_clk);
    endtask

    // Offer a request for exactly one rising edge; returns on the following negedge.
    task automatic request(input logic [3:0] sel);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        @(negedge sys_clk);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        Async_rst = 1'b0;
        cycles(3);
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
        n_cmp++; if (tick_16x !== 1'b0) begin n_bad++; $display("FAIL rst_tick_16x: got %b want 0", tick_16x); end
        n_cmp++; if (tick_1x !== 1'b0) begin n_bad++; $display("FAIL rst_tick_1x: got %b want 0", tick_1x); end
        n_cmp++; if (active_sel !== 4'd6) begin n_bad++; $display("FAIL rst_active_sel: got %0d want 6", active_sel); end
        Async_rst = 1'b1;
        next_tick16(1000, n);
        n_cmp++; if (n !== 650) begin n_bad++; $display("FAIL first_tick16_after_rst: got %0d want 650", n); end
        next_tick16(1000, n);
        n_cmp++; if (n !== 651) begin n_bad++; $display("FAIL tick16_period_9600: got %0d want 651", n); end
        next_tick1x(11000, n);
        next_tick1x(11000, n);
        n_cmp++; if (n !== 10416) begin n_bad++; $display("FAIL tick1x_period_9600: got %0d want 10416", n); end
    endtask

    task automatic test_switch_idle();
        int n;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready_before: got %b want 1", cfg_ready); end
        request(4'd11);
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready_pend: got %b want 0", cfg_ready); end
        n_cmp++; if (active_sel !== 4'd6) begin n_bad++; $display("FAIL idle_sel_t1: got %0d want 6", active_sel); end
        cycles(1);
        n_cmp++; if (active_sel !== 4'd6) begin n_bad++; $display("FAIL idle_sel_load: got %0d want 6", active_sel); end
        n_cmp++; if (tick_16x !== 1'b0) begin n_bad++; $display("FAIL idle_tick_load: got %b want 0", tick_16x); end
        cycles(1);
        n_cmp++; if (active_sel !== 4'd11) begin n_bad++; $display("FAIL idle_sel_applied: got %0d want 11", active_sel); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready_after: got %b want 1", cfg_ready); end
        next_tick16(200, n);
        n_cmp++; if (n !== 53) begin n_bad++; $display("FAIL first_tick16_115200: got %0d want 53", n); end
        next_tick16(200, n);
        n_cmp++; if (n !== 54) begin n_bad++; $display("FAIL tick16_period_115200: got %0d want 54", n); end
        next_tick1x(2000, n);
        next_tick1x(2000, n);
        n_cmp++; if (n !== 864) begin n_bad++; $display("FAIL tick1x_period_115200: got %0d want 864", n); end
    endtask

    task automatic test_busy_hold();
        int n;
        int not_blocked = 0;
        tx_busy = 1'b1;
        request(4'd13);
        for (int i = 0; i < 500; i++) begin
            if (cfg_ready !== 1'b0 || active_sel !== 4'd11) not_blocked++;
            @(negedge sys_clk);
        end
        n_cmp++; if (not_blocked !== 0) begin n_bad++; $display("FAIL busy_hold_blocked: got %0d bad cycles want 0", not_blocked); end
        next_tick16(200, n);
        next_tick16(200, n);
        n_cmp++; if (n !== 54) begin n_bad++; $display("FAIL busy_old_period: got %0d want 54", n); end
        tx_busy = 1'b0;
        cycles(1);
        n_cmp++; if (active_sel !== 4'd11) begin n_bad++; $display("FAIL busy_sel_load: got %0d want 11", active_sel); end
        cycles(1);
        n_cmp++; if (active_sel !== 4'd13) begin n_bad++; $display("FAIL busy_sel_applied: got %0d want 13", active_sel); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL busy_ready_after: got %b want 1", cfg_ready); end
        next_tick16(100, n);
        n_cmp++; if (n !== 23) begin n_bad++; $display("FAIL first_tick16_256000: got %0d want 23", n); end
        next_tick16(100, n);
        n_cmp++; if (n !== 24) begin n_bad++; $display("FAIL tick16_period_256000: got %0d want 24", n); end
    endtask

    task automatic test_invalid();
        int n;
        logic [3:0] bad_sels [2];
        bad_sels[0] = 4'd15;
        bad_sels[1] = 4'd14;
        for (int i = 0; i < 2; i++) begin
            cfg_valid = 1'b1;
            cfg_sel   = bad_sels[i];
            @(negedge sys_clk);
            cfg_valid = 1'b0;
            n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL inv_err_pulse sel %0d: got %b want 1", bad_sels[i], cfg_err); end
            n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL inv_ready sel %0d: got %b want 1", bad_sels[i], cfg_ready); end
            cycles(1);
            n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL inv_err_width sel %0d: got %b want 0", bad_sels[i], cfg_err); end
            cycles(2);
            n_cmp++; if (active_sel !== 4'd13) begin n_bad++; $display("FAIL inv_sel_kept sel %0d: got %0d want 13", bad_sels[i], active_sel); end
        end
        next_tick16(100, n);
        next_tick16(100, n);
        n_cmp++; if (n !== 24) begin n_bad++; $display("FAIL inv_period_kept: got %0d want 24", n); end
    endtask

    task automatic test_second_in_pend();
        int n;
        int err_seen = 0;
        rx_busy = 1'b1;
        request(4'd9);
        cfg_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cfg_sel = (i < 3) ? 4'd10 : 4'd15;
            @(negedge sys_clk);
            if (cfg_err !== 1'b0) err_seen++;
        end
        n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL pend_no_err: got %0d pulses want 0", err_seen); end
        cfg_valid = 1'b0;
        rx_busy   = 1'b0;
        cycles(2);
        n_cmp++; if (active_sel !== 4'd9) begin n_bad++; $display("FAIL pend_first_applied: got %0d want 9", active_sel); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL pend_ready_after: got %b want 1", cfg_ready); end
        next_tick16(400, n);
        next_tick16(400, n);
        n_cmp++; if (n !== 162) begin n_bad++; $display("FAIL pend_period_38400: got %0d want 162", n); end
        cycles(20);
        n_cmp++; if (active_sel !== 4'd9) begin n_bad++; $display("FAIL pend_second_dropped: got %0d want 9", active_sel); end
    endtask

    task automatic test_reset_in_pend();
        int n;
        rx_busy = 1'b1;
        request(4'd0);
        cycles(3);
        n_cmp++; if (active_sel !== 4'd9) begin n_bad++; $display("FAIL rstp_sel_before: got %0d want 9", active_sel); end
        Async_rst = 1'b0;
        #1;
        n_cmp++; if (active_sel !== 4'd6) begin n_bad++; $display("FAIL rstp_sel_async: got %0d want 6", active_sel); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rstp_ready_async: got %b want 1", cfg_ready); end
        cycles(2);
        rx_busy   = 1'b0;
        Async_rst = 1'b1;
        next_tick16(1000, n);
        n_cmp++; if (n !== 650) begin n_bad++; $display("FAIL rstp_first_tick16: got %0d want 650", n); end
        next_tick16(1000, n);
        n_cmp++; if (n !== 651) begin n_bad++; $display("FAIL rstp_period_9600: got %0d want 651", n); end
        cycles(100);
        n_cmp++; if (active_sel !== 4'd6) begin n_bad++; $display("FAIL rstp_sel0_never: got %0d want 6", active_sel); end
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_switch_idle();
        test_busy_hold();
        test_invalid();
        test_second_in_pend();
        test_reset_in_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
